// File: rtl/adder4_pkg.sv
// Shared types and constants for the four-operand sequential adder.
// The ADDER4_SAT_EN macro (see adder4_fmt) selects saturating output;
// by default the result wraps modulo 2^WIDTH.
package adder4_pkg;

  // One state per clock of the fixed four-cycle schedule.
  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_ADD2 = 2'd1,
    S_ADD3 = 2'd2,
    S_ADD4 = 2'd3
  } adder4_state_t;

  // Default operand/result width.
  localparam int WIDTH_DEF = 16;

  // Accumulator width: two guard bits hold the sum of four WIDTH-bit operands.
  localparam int ACC_W_DEF = WIDTH_DEF + 2;

  // Accumulator width for an arbitrary operand width.
  function automatic int acc_w(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/adder4_fmt.sv
// Output formatter: narrows the full-precision accumulator to the result
// width. Define ADDER4_SAT_EN to clamp out-of-range totals to all-ones;
// otherwise the upper bits are dropped (modulo wrap).
module adder4_fmt
  import adder4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ACC_W = acc_w(WIDTH)
) (
  input  logic [ACC_W-1:0] x,
  output logic [WIDTH-1:0] y
);

`ifdef ADDER4_SAT_EN
  // Any set guard bit means the total exceeds the largest representable value.
  always_comb begin
    y = x[WIDTH-1:0];
    if (|x[ACC_W-1:WIDTH]) y = '1;
  end
`else
  // Guard bits are intentionally discarded in the wrapping build.
  logic unused_hi;
  assign unused_hi = ^x[ACC_W-1:WIDTH];

  // Plain truncation to the result width.
  always_comb begin
    y = x[WIDTH-1:0];
  end
`endif

endmodule

// File: rtl/adder4_seq.sv
// Free-running four-operand sequential adder. Operands are sampled on the
// LOAD edge, accumulated over three add edges, and the formatted total is
// registered on sum with a one-cycle fin pulse. Output formatting follows
// the ADDER4_SAT_EN macro (saturate when defined, wrap otherwise).
module adder4_seq
  import adder4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  output logic [WIDTH-1:0] sum,
  output logic             fin
);

  localparam int ACC_W = acc_w(WIDTH);

  adder4_state_t    state;
  adder4_state_t    state_nxt;
  logic [ACC_W-1:0] acc;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] op3;
  logic [WIDTH-1:0] op4;
  logic [ACC_W-1:0] acc_total;
  logic [WIDTH-1:0] sum_fmt;

  // Final addition feeds the formatter directly so sum updates on the ADD4 edge.
  assign acc_total = acc + {2'b00, op4};

  adder4_fmt #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_fmt (
    .x (acc_total),
    .y (sum_fmt)
  );

  // State register; reset parks the schedule at LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_nxt;
  end

  // Fixed rotation with no stalls or idle state.
  always_comb begin
    state_nxt = S_LOAD;
    case (state)
      S_LOAD:  state_nxt = S_ADD2;
      S_ADD2:  state_nxt = S_ADD3;
      S_ADD3:  state_nxt = S_ADD4;
      S_ADD4:  state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  // Operand capture, accumulation and result register; reset discards any in-flight sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      op2 <= '0;
      op3 <= '0;
      op4 <= '0;
      sum <= '0;
      fin <= 1'b0;
    end else begin
      fin <= 1'b0;
      case (state)
        S_LOAD: begin
          acc <= {2'b00, in1};
          op2 <= in2;
          op3 <= in3;
          op4 <= in4;
        end
        S_ADD2: acc <= acc + {2'b00, op2};
        S_ADD3: acc <= acc + {2'b00, op3};
        S_ADD4: begin
          sum <= sum_fmt;
          fin <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder4_seq.sv
// Directed bench for adder4_seq: vector table of four operands and the
// expected result, plus a hand-written asynchronous-reset-in-ADD3 sequence.
module tb_adder4_seq;

  logic        clk;
  logic        rst_n;
  logic [15:0] in1, in2, in3, in4;
  logic [15:0] sum;
  logic        fin;

  int tests = 0;
  int fails = 0;
  logic [15:0] prev_sum;

  typedef struct {
    logic [15:0] a, b, c, d;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [9];

  adder4_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in1   (in1),
    .in2   (in2),
    .in3   (in3),
    .in4   (in4),
    .sum   (sum),
    .fin   (fin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Called at a negedge just before a LOAD edge. Drives the operands, scribbles
  // 1111 on the inputs during the non-LOAD cycles, and checks every cycle.
  task automatic apply(input string name, input vec_t v);
    in1 = v.a; in2 = v.b; in3 = v.c; in4 = v.d;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c < 4) begin
        check({name, " fin low"}, {31'd0, fin}, 32'd0);
        check({name, " sum hold"}, {16'd0, sum}, {16'd0, prev_sum});
        in1 = 16'd1111; in2 = 16'd1111; in3 = 16'd1111; in4 = 16'd1111;
      end else begin
        check({name, " fin pulse"}, {31'd0, fin}, 32'd1);
        check({name, " sum"}, {16'd0, sum}, {16'd0, v.exp});
      end
    end
    prev_sum = v.exp;
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{16'd0,     16'd0,     16'd0,     16'd0,     16'd0};
    vecs[1] = '{16'd3333,  16'd3333,  16'd3333,  16'd3333,  16'd13332};
    vecs[2] = '{16'd5555,  16'd5555,  16'd5555,  16'd5555,  16'd22220};
    vecs[3] = '{16'd1,     16'd2,     16'd3,     16'd4,     16'd10};
    vecs[4] = '{16'd1000,  16'd2000,  16'd3000,  16'd4000,  16'd10000};
    vecs[5] = '{16'h7FFF,  16'h8000,  16'h0000,  16'h0000,  16'hFFFF};
`ifdef ADDER4_SAT_EN
    vecs[6] = '{16'hFFFF,  16'hFFFF,  16'hFFFF,  16'hFFFF,  16'hFFFF};
    vecs[7] = '{16'h8000,  16'h8000,  16'h0000,  16'h0000,  16'hFFFF};
    vecs[8] = '{16'hFFFF,  16'h0000,  16'h0000,  16'h0001,  16'hFFFF};
`else
    vecs[6] = '{16'hFFFF,  16'hFFFF,  16'hFFFF,  16'hFFFF,  16'hFFFC};
    vecs[7] = '{16'h8000,  16'h8000,  16'h0000,  16'h0000,  16'h0000};
    vecs[8] = '{16'hFFFF,  16'h0000,  16'h0000,  16'h0001,  16'h0000};
`endif

    rst_n = 1'b0;
    in1 = '0; in2 = '0; in3 = '0; in4 = '0;
    prev_sum = '0;

    #3;
    check("reset sum", {16'd0, sum}, 32'd0);
    check("reset fin", {31'd0, fin}, 32'd0);
    #4;
    check("reset sum held", {16'd0, sum}, 32'd0);
    #3;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Async reset while in S_ADD3 aborts an in-flight 2222*4 sum.
    in1 = 16'd2222; in2 = 16'd2222; in3 = 16'd2222; in4 = 16'd2222;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst sum", {16'd0, sum}, 32'd0);
    check("async rst fin", {31'd0, fin}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst held fin", {31'd0, fin}, 32'd0);
      check("rst held sum", {16'd0, sum}, 32'd0);
    end
    rst_n = 1'b1;
    prev_sum = '0;
    rv = '{16'd2222, 16'd2222, 16'd2222, 16'd2222, 16'd8888};
    apply("restart", rv);
    rv = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd100};
    apply("after restart", rv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
